// File: rtl/lsu_mmio_pkg.sv
// lsu_mmio_pkg
//   Shared types and helpers for the LSU-side MMIO master.
//   - size_e  : request size encoding (byte / half / word / reserved)
//   - state_e : one-hot FSM state encoding of lsu_mmio_master
//   - bytes_of(size)          : bus transfer length in bytes, zero-extended to 32 bits
//   - misaligned(addr, size)  : natural-alignment check on the low address bits
package lsu_mmio_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_R = 2'd3
    } size_e;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_AR   = 5'b00010,
        ST_R    = 5'b00100,
        ST_W    = 5'b01000,
        ST_RESP = 5'b10000
    } state_e;

    function automatic logic [31:0] bytes_of(input size_e size);
        return 32'd1 << size;
    endfunction

    // Only the two low address bits matter for alignment.
    function automatic logic misaligned(input logic [1:0] addr_lo, input size_e size);
        case (size)
            SZ_H:    return addr_lo[0];
            SZ_W:    return (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mmio_master_if.sv
// lsu_mmio_master_if
//   MMIO bus between lsu_mmio_master and the mmio_dpi slave.
//   Read address : arAddr, arWidth, arValid (master) / arReady (slave)
//   Read data    : rData, rValid (slave) / rReady (master)
//   Write        : wAddr, wData, wWidth, wValid (master) / wReady (slave)
interface lsu_mmio_master_if;

    logic [31:0] arAddr;
    logic [31:0] arWidth;
    logic        arValid;
    logic        arReady;

    logic [31:0] rData;
    logic        rValid;
    logic        rReady;

    logic [31:0] wAddr;
    logic [31:0] wData;
    logic [31:0] wWidth;
    logic        wValid;
    logic        wReady;

    modport master (
        output arAddr, arWidth, arValid,
        input  arReady,
        input  rData, rValid,
        output rReady,
        output wAddr, wData, wWidth, wValid,
        input  wReady
    );

    modport slave (
        input  arAddr, arWidth, arValid,
        output arReady,
        output rData, rValid,
        input  rReady,
        input  wAddr, wData, wWidth, wValid,
        output wReady
    );

endinterface

// File: rtl/lsu_load_ext.sv
// lsu_load_ext
//   Combinational load-data extension.
//   i_rdata    : raw read data, valid bytes in the low bits
//   i_size     : SZ_B / SZ_H / SZ_W
//   i_unsigned : 1 = zero-extend, 0 = sign-extend
//   o_data     : extended 32-bit word
module lsu_load_ext
    import lsu_mmio_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  size_e       i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic w_sign_b;
    logic w_sign_h;

    assign w_sign_b = ~i_unsigned & i_rdata[7];
    assign w_sign_h = ~i_unsigned & i_rdata[15];

    always_comb begin
        o_data = i_rdata;
        case (i_size)
            SZ_B:    o_data = {{24{w_sign_b}}, i_rdata[7:0]};
            SZ_H:    o_data = {{16{w_sign_h}}, i_rdata[15:0]};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mmio_master.sv
// lsu_mmio_master
//   Takes one load/store request at a time from the core LSU, checks alignment,
//   runs the MMIO read (AR/R) or write (W) transaction and returns a single
//   response pulse. Every bus wait is bounded by TIMEOUT_CYCLES (0 = unbounded).
//   clk, reset      : single clock, synchronous active-high reset
//   req_*           : LSU request (valid/ready, wen, addr, wdata, size, unsigned)
//   resp_*          : one-cycle response pulse with extended load data and error
//   bus (master)    : MMIO AR/R/W channels toward the slave
module lsu_mmio_master
    import lsu_mmio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_wen,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    input  logic [1:0]                req_size,
    input  logic                      req_unsigned,
    output logic                      resp_valid,
    output logic [31:0]               resp_data,
    output logic                      resp_err,
    lsu_mmio_master_if.master         bus
);

    // Counter value of the last cycle allowed in a wait state: a wait state is
    // occupied for exactly TIMEOUT_CYCLES cycles before the abort.
    localparam logic [CNT_W-1:0] LP_TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_width;
    size_e            r_size;
    logic             r_unsigned;
    logic [31:0]      r_resp_data;
    logic             r_resp_err;

    size_e            w_req_size;
    logic             w_req_bad;
    logic             w_timeout;
    logic             w_in_wait;
    logic [31:0]      w_ext;

    assign w_req_size = size_e'(req_size);
    assign w_req_bad  = (w_req_size == SZ_R) || misaligned(req_addr[1:0], w_req_size);
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_cnt == LP_TO_LAST);
    assign w_in_wait  = (r_state == ST_AR) || (r_state == ST_R) || (r_state == ST_W);

    lsu_load_ext u_ext (
        .i_rdata    (bus.rData),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_ext)
    );

    // Next-state logic; a handshake in the same cycle as the timeout wins.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_req_bad)    w_next = ST_RESP;
                    else if (req_wen) w_next = ST_W;
                    else              w_next = ST_AR;
                end
            end
            ST_AR: begin
                if (bus.arReady)    w_next = ST_R;
                else if (w_timeout) w_next = ST_RESP;
            end
            ST_R: begin
                if (bus.rValid || w_timeout) w_next = ST_RESP;
            end
            ST_W: begin
                if (bus.wReady || w_timeout) w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_width     <= '0;
            r_size      <= SZ_B;
            r_unsigned  <= 1'b0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            r_state <= w_next;

            // Cleared on every state change so each wait state starts from zero.
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_in_wait)
                r_cnt <= r_cnt + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_width     <= bytes_of(w_req_size);
                        r_size      <= w_req_size;
                        r_unsigned  <= req_unsigned;
                        r_resp_data <= '0;
                        r_resp_err  <= w_req_bad;
                    end
                end
                ST_AR: begin
                    if (!bus.arReady && w_timeout) r_resp_err <= 1'b1;
                end
                ST_R: begin
                    if (bus.rValid)     r_resp_data <= w_ext;
                    else if (w_timeout) r_resp_err  <= 1'b1;
                end
                ST_W: begin
                    if (!bus.wReady && w_timeout) r_resp_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign resp_valid  = (r_state == ST_RESP);
    assign resp_data   = r_resp_data;
    assign resp_err    = r_resp_err;

    // Address/data/width stay registered so the slave can sample them a cycle
    // after the handshake.
    assign bus.arValid = (r_state == ST_AR);
    assign bus.rReady  = (r_state == ST_R);
    assign bus.wValid  = (r_state == ST_W);
    assign bus.arAddr  = r_addr;
    assign bus.arWidth = r_width;
    assign bus.wAddr   = r_addr;
    assign bus.wData   = r_wdata;
    assign bus.wWidth  = r_width;

endmodule

// File: tb/tb_lsu_mmio_master.sv
// tb_lsu_mmio_master
//   Directed bench for lsu_mmio_master with a response scoreboard.
module tb_lsu_mmio_master;
    import lsu_mmio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    lsu_mmio_master_if bus ();

    lsu_mmio_master #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_err      = 0;
    int   n_chk      = 0;
    int   n_resp     = 0;
    int   n_wr_hs    = 0;
    int   n_bus_vld  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %h, want %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every response pulse is compared against the oldest
    // expectation; bus activity is tallied for the no-traffic checks.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            n_resp++;
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {31'b0, resp_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_data", resp_data, mon_e.data);
                check("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
            end
        end
        if (bus.wValid === 1'b1 && bus.wReady === 1'b1) n_wr_hs++;
        if (bus.arValid === 1'b1 || bus.wValid === 1'b1) n_bus_vld++;
    end

    task automatic push_exp(input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("req_ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        step();
        req_valid    = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input logic [31:0] rdata, input logic [31:0] expd);
        logic [31:0] w;
        w = 32'd1 << size;
        push_exp(expd, 1'b0);
        do_req(1'b0, addr, 32'h0, size, uns);
        check("arValid", {31'b0, bus.arValid}, 32'd1);
        check("arAddr", bus.arAddr, addr);
        check("arWidth", bus.arWidth, w);
        bus.arReady = 1'b1;
        step();
        bus.arReady = 1'b0;
        check("rReady", {31'b0, bus.rReady}, 32'd1);
        check("arValid_after_hs", {31'b0, bus.arValid}, 32'd0);
        check("arAddr_held", bus.arAddr, addr);
        bus.rData  = rdata;
        bus.rValid = 1'b1;
        step();
        bus.rValid = 1'b0;
        bus.rData  = 32'h0;
        check("resp_valid_after_r", {31'b0, resp_valid}, 32'd1);
        step();
        check("resp_valid_one_cycle", {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int base;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_wen      = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        bus.arReady  = 1'b0;
        bus.rData    = 32'h0;
        bus.rValid   = 1'b0;
        bus.wReady   = 1'b0;
        repeat (3) step();

        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_arValid", {31'b0, bus.arValid}, 32'd0);
        check("rst_rReady", {31'b0, bus.rReady}, 32'd0);
        check("rst_wValid", {31'b0, bus.wValid}, 32'd0);
        check("rst_arAddr", bus.arAddr, 32'h0);
        check("rst_wData", bus.wData, 32'h0);
        check("rst_wWidth", bus.wWidth, 32'h0);
        reset = 1'b0;
        step();

        // Loads with sign/zero extension
        do_load(32'h8000_0003, 2'd0, 1'b0, 32'h0000_00F0, 32'hFFFF_FFF0);
        do_load(32'hA000_0002, 2'd1, 1'b1, 32'h0000_8001, 32'h0000_8001);
        do_load(32'hA000_0002, 2'd1, 1'b0, 32'h0000_8001, 32'hFFFF_8001);
        do_load(32'h8000_0004, 2'd2, 1'b0, 32'h89AB_CDEF, 32'h89AB_CDEF);
        do_load(32'h8000_0001, 2'd0, 1'b1, 32'h1234_56A5, 32'h0000_00A5);
        do_load(32'h8000_0006, 2'd1, 1'b0, 32'hFFFF_7FFF, 32'h0000_7FFF);

        // Alignment / reserved-size errors: no bus traffic at all
        base = n_bus_vld;
        push_exp(32'h0, 1'b1);
        do_req(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0);
        check("misal_w_resp", {31'b0, resp_valid}, 32'd1);
        step();
        push_exp(32'h0, 1'b1);
        do_req(1'b1, 32'h8000_0000, 32'h1234, 2'd3, 1'b0);
        check("size3_resp", {31'b0, resp_valid}, 32'd1);
        step();
        push_exp(32'h0, 1'b1);
        do_req(1'b0, 32'h8000_0001, 32'h0, 2'd1, 1'b0);
        check("misal_h_resp", {31'b0, resp_valid}, 32'd1);
        step();
        check("err_no_bus_valid", 32'(n_bus_vld - base), 32'd0);

        // Store word
        base = n_wr_hs;
        push_exp(32'h0, 1'b0);
        do_req(1'b1, 32'hA000_03F8, 32'hDEAD_BEEF, 2'd2, 1'b0);
        check("wValid", {31'b0, bus.wValid}, 32'd1);
        check("wAddr", bus.wAddr, 32'hA000_03F8);
        check("wData", bus.wData, 32'hDEAD_BEEF);
        check("wWidth", bus.wWidth, 32'd4);
        bus.wReady = 1'b1;
        step();
        bus.wReady = 1'b0;
        check("store_resp", {31'b0, resp_valid}, 32'd1);
        check("wValid_drop", {31'b0, bus.wValid}, 32'd0);
        check("wAddr_held", bus.wAddr, 32'hA000_03F8);
        check("wData_held", bus.wData, 32'hDEAD_BEEF);
        check("wWidth_held", bus.wWidth, 32'd4);
        step();
        check("one_write", 32'(n_wr_hs - base), 32'd1);

        // Timeout on AR with arReady held low
        push_exp(32'h0, 1'b1);
        do_req(1'b0, 32'h8000_1000, 32'h0, 2'd2, 1'b0);
        n = 0;
        while (bus.arValid === 1'b1 && n < 20) begin
            n++;
            step();
        end
        check("ar_timeout_cycles", 32'(n), 32'd8);
        check("timeout_resp", {31'b0, resp_valid}, 32'd1);
        check("timeout_arValid", {31'b0, bus.arValid}, 32'd0);
        step();
        do_load(32'h8000_0010, 2'd2, 1'b1, 32'h0102_0304, 32'h0102_0304);

        // Timeout on W with wReady held low
        push_exp(32'h0, 1'b1);
        do_req(1'b1, 32'h8000_2000, 32'h5555_AAAA, 2'd2, 1'b0);
        n = 0;
        while (bus.wValid === 1'b1 && n < 20) begin
            n++;
            step();
        end
        check("w_timeout_cycles", 32'(n), 32'd8);
        check("w_timeout_resp", {31'b0, resp_valid}, 32'd1);
        step();

        // Reset while waiting in R: abort silently
        do_req(1'b0, 32'h8000_0020, 32'h0, 2'd2, 1'b0);
        bus.arReady = 1'b1;
        step();
        bus.arReady = 1'b0;
        check("in_R", {31'b0, bus.rReady}, 32'd1);
        base = n_resp;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_req_ready", {31'b0, req_ready}, 32'd1);
        check("abort_arValid", {31'b0, bus.arValid}, 32'd0);
        check("abort_rReady", {31'b0, bus.rReady}, 32'd0);
        check("abort_wValid", {31'b0, bus.wValid}, 32'd0);
        check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        repeat (3) step();
        check("abort_no_resp", 32'(n_resp - base), 32'd0);
        do_load(32'h8000_0024, 2'd0, 1'b0, 32'h0000_007F, 32'h0000_007F);

        repeat (2) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
